sram_dual_arbiter: RTL and testbench

//  Shares the single off-chip 16-bit async SRAM (sram_* pins) between two requesters:

---
 rtl/sram_dual_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_sram_dual_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dual_arbiter.sv
// sram_dual_arbiter: shares one external 16-bit asynchronous SRAM between two requesters.
//   Port 0 is the VGA frame fetch. Port 1 is the audio sample store / CPU bridge.
//   Each access is arbitrated on its own. The SRAM strobes are held for a fixed window
//   of ACCESS_CYCLES cycles. After that, one bus-turnaround cycle returns a single-cycle
//   completion pulse, together with the read data, to the port that was granted.
// Build option:
//   SRAM_ARB_FIXED_PRIO_EN  when defined, port 0 always wins contention.
//                           Otherwise the two ports are served round-robin.
module sram_dual_arbiter #(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 16,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [1:0]        req0_be,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic [1:0]        req1_be,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,

    inout  wire  [DATA_W-1:0] sram_DQ,
    output logic [ADDR_W-1:0] sram_ADDR,
    output logic              sram_LB_N,
    output logic              sram_UB_N,
    output logic              sram_CE_N,
    output logic              sram_OE_N,
    output logic              sram_WE_N
);

    // state   | meaning
    // IDLE    | strobes high, DQ released, accepting the arbitration winner
    // ACCESS  | CE_N and lane strobes low, plus OE_N (read) or WE_N with DQ driven (write)
    // RECOVER | all strobes high, DQ released for turnaround, completion pulse out
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              port_q;
    logic              write_q;
    logic              dq_oe;
    logic [DATA_W-1:0] wdata_q;

    logic              grant0;
    logic              grant1;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [1:0]        sel_be;

`ifndef SRAM_ARB_FIXED_PRIO_EN
    // 1 means port 1 was granted last, so port 0 wins the next contention.
    logic              last_grant;
`endif

    // Pick the winner among pending requests. The result is only used while in IDLE.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        grant0 = req0_valid;
        grant1 = req1_valid & ~req0_valid;
`else
        if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = ~last_grant;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
`endif
    end

    // Route the winning port's request fields toward the latch stage.
    always_comb begin
        sel_write = req0_write;
        sel_addr  = req0_addr;
        sel_wdata = req0_wdata;
        sel_be    = req0_be;
        if (grant1) begin
            sel_write = req1_write;
            sel_addr  = req1_addr;
            sel_wdata = req1_wdata;
            sel_be    = req1_be;
        end
    end

    // The ready outputs are gated by reset so that no handshake can occur while in reset.
    assign req0_ready = reset_reset_n & (state == IDLE) & grant0;
    assign req1_ready = reset_reset_n & (state == IDLE) & grant1;

    // DQ is driven only during write ACCESS cycles, and OE_N is held high whenever that happens.
    assign sram_DQ = dq_oe ? wdata_q : {DATA_W{1'bz}};

    // Access sequencer. All SRAM strobes and all responses are registered here.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            port_q     <= 1'b0;
            write_q    <= 1'b0;
            dq_oe      <= 1'b0;
            wdata_q    <= '0;
            sram_ADDR  <= '0;
            sram_LB_N  <= 1'b1;
            sram_UB_N  <= 1'b1;
            sram_CE_N  <= 1'b1;
            sram_OE_N  <= 1'b1;
            sram_WE_N  <= 1'b1;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_rdata <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        port_q    <= grant1;
                        write_q   <= sel_write;
                        wdata_q   <= sel_wdata;
                        sram_ADDR <= sel_addr;
                        cnt       <= 4'(ACCESS_CYCLES - 1);
                        sram_CE_N <= 1'b0;
                        sram_LB_N <= ~sel_be[0];
                        sram_UB_N <= ~sel_be[1];
                        sram_OE_N <= sel_write;
                        sram_WE_N <= ~sel_write;
                        dq_oe     <= sel_write;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                        last_grant <= grant1;
`endif
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!write_q) begin
                            if (port_q) rsp1_rdata <= sram_DQ;
                            else        rsp0_rdata <= sram_DQ;
                        end
                        rsp0_valid <= ~port_q;
                        rsp1_valid <= port_q;
                        sram_CE_N  <= 1'b1;
                        sram_OE_N  <= 1'b1;
                        sram_WE_N  <= 1'b1;
                        sram_LB_N  <= 1'b1;
                        sram_UB_N  <= 1'b1;
                        dq_oe      <= 1'b0;
                        state      <= RECOVER;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RECOVER: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_dual_arbiter.sv
// Bench for sram_dual_arbiter.
// It contains a behavioural SRAM on the pins and a transaction-level reference model
// (arbitration rule, busy window, expected-response queue, reference memory).
// The stimulus comes in three forms: a table of single accesses, randomized traffic,
// and hand-written sequences for reset during an access and for continuous contention.
// It honours SRAM_ARB_FIXED_PRIO_EN the same way the design does.
module tb_sram_dual_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int AC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    logic          p_v  [2];
    logic          p_w  [2];
    logic [AW-1:0] p_a  [2];
    logic [DW-1:0] p_d  [2];
    logic [1:0]    p_be [2];

    logic          rdy0, rdy1, rv0, rv1;
    logic [DW-1:0] rd0, rd1;
    wire  [DW-1:0] sram_DQ;
    logic [AW-1:0] sram_ADDR;
    logic          sram_LB_N, sram_UB_N, sram_CE_N, sram_OE_N, sram_WE_N;

    sram_dual_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .req0_valid    (p_v[0]),
        .req0_write    (p_w[0]),
        .req0_addr     (p_a[0]),
        .req0_wdata    (p_d[0]),
        .req0_be       (p_be[0]),
        .req0_ready    (rdy0),
        .rsp0_valid    (rv0),
        .rsp0_rdata    (rd0),
        .req1_valid    (p_v[1]),
        .req1_write    (p_w[1]),
        .req1_addr     (p_a[1]),
        .req1_wdata    (p_d[1]),
        .req1_be       (p_be[1]),
        .req1_ready    (rdy1),
        .rsp1_valid    (rv1),
        .rsp1_rdata    (rd1),
        .sram_DQ       (sram_DQ),
        .sram_ADDR     (sram_ADDR),
        .sram_LB_N     (sram_LB_N),
        .sram_UB_N     (sram_UB_N),
        .sram_CE_N     (sram_CE_N),
        .sram_OE_N     (sram_OE_N),
        .sram_WE_N     (sram_WE_N)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural SRAM on the pins ----------------
    logic [DW-1:0] mem [logic [AW-1:0]];
    int            mem_ver = 0;
    logic [DW-1:0] sram_rd = '0;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    always @(sram_ADDR or mem_ver)
        sram_rd = mem.exists(sram_ADDR) ? mem[sram_ADDR] : init_val(sram_ADDR);

    assign sram_DQ = (!sram_CE_N && !sram_OE_N && sram_WE_N) ? sram_rd : {DW{1'bz}};

    int we_cnt = 0;
    int ub_cnt = 0;
    int lb_cnt = 0;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (!sram_CE_N && !sram_WE_N) begin
                logic [DW-1:0] o;
                o = mem.exists(sram_ADDR) ? mem[sram_ADDR] : init_val(sram_ADDR);
                if (!sram_LB_N) o[7:0]  = sram_DQ[7:0];
                if (!sram_UB_N) o[15:8] = sram_DQ[15:8];
                mem[sram_ADDR] = o;
                mem_ver++;
            end
            if (!sram_WE_N) we_cnt++;
            if (!sram_UB_N) ub_cnt++;
            if (!sram_LB_N) lb_cnt++;
            chk("we_oe_exclusive", 32'(sram_WE_N | sram_OE_N), 32'd1);
            if (!sram_CE_N && !sram_OE_N)
                chk("dq_read_no_contention", 32'(sram_DQ), 32'(sram_rd));
            if (rv0 || rv1)
                chk("recover_strobes_high",
                    32'({sram_CE_N, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N}), 32'h1F);
        end
    end

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        int            port;
        int            due;
        bit            rd;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          eq[$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    bit            m_last = 1'b1;
    int            m_free = 0;
    int            act_g;
    int            last_rsp_port, last_rsp_cyc;
    logic [DW-1:0] last_rsp_data;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // One cycle: check ready/response at the negedge, then book any accepted request.
    task automatic step(output int acc);
        int            eg;
        logic [1:0]    ev;
        logic [DW-1:0] ra;
        logic [DW-1:0] nv;
        @(negedge clk);
        eg = -1;
        if (cyc >= m_free) begin
            if (p_v[0] && p_v[1]) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
                eg = 0;
`else
                eg = m_last ? 0 : 1;
`endif
            end else if (p_v[0]) begin
                eg = 0;
            end else if (p_v[1]) begin
                eg = 1;
            end
        end
        act_g = rdy0 ? 0 : (rdy1 ? 1 : -1);
        chk("ready", 32'({rdy1, rdy0}), (eg == 0) ? 32'd1 : (eg == 1) ? 32'd2 : 32'd0);
        if (rv0) begin
            last_rsp_port = 0; last_rsp_data = rd0; last_rsp_cyc = cyc;
        end else if (rv1) begin
            last_rsp_port = 1; last_rsp_data = rd1; last_rsp_cyc = cyc;
        end
        ev = 2'b00;
        if (eq.size() > 0 && eq[0].due == cyc) begin
            ev[eq[0].port] = 1'b1;
            if (eq[0].rd)
                chk("rsp_rdata", 32'((eq[0].port == 0) ? rd0 : rd1), 32'(eq[0].data));
            void'(eq.pop_front());
        end
        chk("rsp_valid", 32'({rv1, rv0}), 32'(ev));
        if (eg >= 0) begin
            m_last = eg[0];
            m_free = cyc + AC + 2;
            ra = ref_rd(p_a[eg]);
            eq.push_back('{eg, cyc + AC + 1, !p_w[eg], ra});
            if (p_w[eg]) begin
                nv = ra;
                if (p_be[eg][0]) nv[7:0]  = p_d[eg][7:0];
                if (p_be[eg][1]) nv[15:8] = p_d[eg][15:8];
                ref_mem[p_a[eg]] = nv;
            end
        end
        acc = eg;
    endtask

    task automatic new_req(input int p, input int pct);
        p_v[p]  = ($urandom_range(0, 99) < pct);
        p_w[p]  = 1'($urandom_range(0, 1));
        p_a[p]  = 20'($urandom_range(0, 7) * 32'h12345);
        p_d[p]  = 16'($urandom);
        p_be[p] = p_w[p] ? 2'($urandom_range(0, 3)) : 2'b11;
    endtask

    task automatic drain();
        int acc;
        p_v[0] = 1'b0;
        p_v[1] = 1'b0;
        for (int k = 0; k < AC + 3; k++) step(acc);
        chk("drain_empty", 32'(eq.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit v0; bit w0; logic [AW-1:0] a0; logic [DW-1:0] d0; logic [1:0] be0;
        bit v1; bit w1; logic [AW-1:0] a1; logic [DW-1:0] d1; logic [1:0] be1;
        int exp_port; bit chk_rd; logic [DW-1:0] exp_rd;
    } vec_t;

    function automatic vec_t mk(
        bit v0, bit w0, logic [AW-1:0] a0, logic [DW-1:0] d0, logic [1:0] be0,
        bit v1, bit w1, logic [AW-1:0] a1, logic [DW-1:0] d1, logic [1:0] be1,
        int ep, bit crd, logic [DW-1:0] erd);
        vec_t r;
        r.v0 = v0; r.w0 = w0; r.a0 = a0; r.d0 = d0; r.be0 = be0;
        r.v1 = v1; r.w1 = w1; r.a1 = a1; r.d1 = d1; r.be1 = be1;
        r.exp_port = ep; r.chk_rd = crd; r.exp_rd = erd;
        return r;
    endfunction

    vec_t tbl [11];
    int   alt_exp [4];

    initial begin
        int acc, acc_cyc, g, n_acc;
        logic          ew;
        logic [1:0]    ebe;

        tbl[0]  = mk(1, 1, 20'h00010, 16'hBEEF, 2'b11, 0, 0, 20'h0, 16'h0, 2'b11, 0, 0, 16'h0);
        tbl[1]  = mk(1, 0, 20'h00010, 16'h0000, 2'b11, 0, 0, 20'h0, 16'h0, 2'b11, 0, 1, 16'hBEEF);
        tbl[2]  = mk(1, 1, 20'h00010, 16'h1234, 2'b01, 0, 0, 20'h0, 16'h0, 2'b11, 0, 0, 16'h0);
        tbl[3]  = mk(1, 0, 20'h00010, 16'h0000, 2'b11, 0, 0, 20'h0, 16'h0, 2'b11, 0, 1, 16'hBE34);
        tbl[4]  = mk(0, 0, 20'h0, 16'h0, 2'b11, 1, 1, 20'h00020, 16'hCAFE, 2'b11, 1, 0, 16'h0);
        tbl[5]  = mk(1, 0, 20'h00010, 16'h0, 2'b11, 1, 0, 20'h00020, 16'h0, 2'b11, 0, 1, 16'hBE34);
`ifdef SRAM_ARB_FIXED_PRIO_EN
        tbl[6]  = mk(1, 0, 20'h00010, 16'h0, 2'b11, 1, 0, 20'h00020, 16'h0, 2'b11, 0, 1, 16'hBE34);
        alt_exp[0] = 0; alt_exp[1] = 0; alt_exp[2] = 0; alt_exp[3] = 0;
`else
        tbl[6]  = mk(1, 0, 20'h00010, 16'h0, 2'b11, 1, 0, 20'h00020, 16'h0, 2'b11, 1, 1, 16'hCAFE);
        alt_exp[0] = 0; alt_exp[1] = 1; alt_exp[2] = 0; alt_exp[3] = 1;
`endif
        tbl[7]  = mk(0, 0, 20'h0, 16'h0, 2'b11, 1, 1, 20'h00020, 16'h0000, 2'b00, 1, 0, 16'h0);
        tbl[8]  = mk(0, 0, 20'h0, 16'h0, 2'b11, 1, 0, 20'h00020, 16'h0, 2'b11, 1, 1, 16'hCAFE);
        tbl[9]  = mk(1, 1, 20'hFFFFF, 16'hAB00, 2'b10, 0, 0, 20'h0, 16'h0, 2'b11, 0, 0, 16'h0);
        tbl[10] = mk(0, 0, 20'h0, 16'h0, 2'b11, 1, 0, 20'hFFFFF, 16'h0, 2'b11, 1, 1, 16'hABA5);

        // Reset state. Valid requests are present, yet no handshake may occur during reset.
        for (int p = 0; p < 2; p++) begin
            p_v[p] = 1'b1; p_w[p] = 1'b0; p_a[p] = 20'h00040; p_d[p] = '0; p_be[p] = 2'b11;
        end
        rst_n = 1'b0;
        #12;
        chk("reset_ready", 32'({rdy1, rdy0}), 32'd0);
        chk("reset_rsp_valid", 32'({rv1, rv0}), 32'd0);
        chk("reset_rdata", {rd1, rd0}, 32'd0);
        chk("reset_strobes", 32'({sram_CE_N, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N}), 32'h1F);
        chk("reset_addr", 32'(sram_ADDR), 32'd0);
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table of single accesses.
        for (int i = 0; i < 11; i++) begin
            p_v[0] = tbl[i].v0; p_w[0] = tbl[i].w0; p_a[0] = tbl[i].a0;
            p_d[0] = tbl[i].d0; p_be[0] = tbl[i].be0;
            p_v[1] = tbl[i].v1; p_w[1] = tbl[i].w1; p_a[1] = tbl[i].a1;
            p_d[1] = tbl[i].d1; p_be[1] = tbl[i].be1;
            ew  = (tbl[i].exp_port == 0) ? tbl[i].w0  : tbl[i].w1;
            ebe = (tbl[i].exp_port == 0) ? tbl[i].be0 : tbl[i].be1;
            last_rsp_cyc = -1; last_rsp_port = -1; last_rsp_data = '0;
            acc_cyc = -1; g = -1;
            for (int k = 0; k < 8; k++) begin
                step(acc);
                if (acc >= 0) begin
                    acc_cyc = cyc;
                    g = act_g;
                    break;
                end
            end
            chk("tbl_accept_port", 32'(g), 32'(tbl[i].exp_port));
            @(posedge clk); #1;
            p_v[0] = 1'b0; p_v[1] = 1'b0;
            we_cnt = 0; ub_cnt = 0; lb_cnt = 0;
            for (int k = 0; k < AC + 1; k++) step(acc);
            chk("tbl_rsp_latency", 32'(last_rsp_cyc), 32'(acc_cyc + AC + 1));
            chk("tbl_rsp_port", 32'(last_rsp_port), 32'(tbl[i].exp_port));
            if (tbl[i].chk_rd) chk("tbl_rdata", 32'(last_rsp_data), 32'(tbl[i].exp_rd));
            chk("tbl_we_cycles", 32'(we_cnt), ew ? 32'(AC) : 32'd0);
            chk("tbl_ub_cycles", 32'(ub_cnt), ebe[1] ? 32'(AC) : 32'd0);
            chk("tbl_lb_cycles", 32'(lb_cnt), ebe[0] ? 32'(AC) : 32'd0);
            @(posedge clk); #1;
        end

        // Randomized traffic: moderate load first, then saturation on both ports.
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            step(acc);
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++)
                if (act_g == p || !p_v[p]) new_req(p, (i < 2000) ? 60 : 100);
        end
        drain();

        // Reset in the middle of a write: the strobes must release at once and no response may follow.
        p_v[0] = 1'b1; p_w[0] = 1'b1; p_a[0] = 20'h00300; p_d[0] = 16'h5555; p_be[0] = 2'b11;
        acc = -1;
        for (int k = 0; k < 8 && acc < 0; k++) step(acc);
        chk("midwr_accept", 32'(acc), 32'd0);
        @(posedge clk); #1;
        p_v[0] = 1'b0;
        @(negedge clk);
        chk("midwr_we_active", 32'({sram_CE_N, sram_WE_N}), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midwr_reset_strobes",
            32'({sram_CE_N, sram_OE_N, sram_WE_N, sram_LB_N, sram_UB_N}), 32'h1F);
        chk("midwr_reset_rsp", 32'({rv1, rv0}), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midwr_no_rsp", 32'({rv1, rv0}), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_last = 1'b1;
        m_free = 0;
        eq.delete();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("post_reset_no_rsp", 32'({rv1, rv0}), 32'd0);
        end
        @(posedge clk); #1;

        // Continuous contention after reset: port 0 gets the first grant.
        for (int p = 0; p < 2; p++) begin
            p_v[p] = 1'b1; p_w[p] = 1'b0; p_a[p] = 20'(32'h12345 * (p + 1)); p_be[p] = 2'b11;
        end
        n_acc = 0;
        for (int k = 0; k < 40 && n_acc < 4; k++) begin
            step(acc);
            if (act_g >= 0) begin
                chk("alt_grant", 32'(act_g), 32'(alt_exp[n_acc]));
                n_acc++;
            end
            @(posedge clk); #1;
            if (act_g >= 0) p_a[act_g] = 20'($urandom_range(0, 7) * 32'h12345);
        end
        chk("alt_grant_count", 32'(n_acc), 32'd4);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
